// File: rtl/rv32i_types.sv
// Shared core types: physical register / ROB index widths and the CDB packet.
package rv32i_types;
  localparam int PHYS_REG_IDX = 5;   // pid is PHYS_REG_IDX+1 bits wide
  localparam int ROB_IDX_W    = 4;
  localparam int NUM_CDB_SRC  = 4;   // ALU, MUL, DIV, LSU
  localparam int CDB_XLEN     = 32;

  typedef struct packed {
    logic [PHYS_REG_IDX:0]  pid;
    logic [CDB_XLEN-1:0]    value;
    logic [ROB_IDX_W-1:0]   rob_idx;
  } cdb_pkt_t;
endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer. ready depends only on registered occupancy so a
// producer never sees a combinational path through the arbiter's dequeue.
module cdb_src_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  output logic         ready,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign ready   = count < (AW+1)'(DEPTH);
  assign empty   = (count == '0);
  assign rd_data = mem[rptr];
  // a flushed cycle neither accepts nor retires anything
  assign push    = wr_valid & ready & ~flush;
  assign pop     = rd_en & ~empty & ~flush;

  // storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // pointers and occupancy; power-of-two depth makes the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from each functional unit and
// broadcasts one per cycle, round-robin across sources, from a registered output.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = NUM_CDB_SRC,
  parameter int DEPTH   = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush,
  input  logic [NUM_SRC-1:0]                        src_valid,
  output logic [NUM_SRC-1:0]                        src_ready,
  input  logic [NUM_SRC-1:0][PHYS_REG_IDX:0]        src_pid,
  input  logic [NUM_SRC-1:0][XLEN-1:0]              src_value,
  input  logic [NUM_SRC-1:0][ROB_IDX_W-1:0]         src_rob_idx,
  output logic                                      cdb_valid,
  output logic                                      cdb_regwrite,
  output logic [PHYS_REG_IDX:0]                     cdb_pid,
  output logic [XLEN-1:0]                           cdb_value,
  output logic [ROB_IDX_W-1:0]                      cdb_rob_idx
);
  localparam int PID_W = PHYS_REG_IDX + 1;
  localparam int PKT_W = PID_W + XLEN + ROB_IDX_W;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0][PKT_W-1:0] head;
  logic [NUM_SRC-1:0]            empty, rd_en;
  logic [SRC_W-1:0]              rr_ptr, gnt_idx;
  logic                          gnt_any;
  logic [PKT_W-1:0]              gnt_pkt, out_pkt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    cdb_src_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .wr_valid (src_valid[g]),
      .wr_data  ({src_pid[g], src_value[g], src_rob_idx[g]}),
      .ready    (src_ready[g]),
      .rd_en    (rd_en[g]),
      .rd_data  (head[g]),
      .empty    (empty[g])
    );
  end

  // round-robin pick: scan from rr_ptr; descending loop so the nearest source wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (!empty[(int'(rr_ptr) + k) % NUM_SRC]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  // one-hot dequeue of the granted head; squashed cycles retire nothing
  always_comb begin
    rd_en = '0;
    for (int i = 0; i < NUM_SRC; i++)
      rd_en[i] = gnt_any && !flush && (gnt_idx == SRC_W'(i));
  end

  assign gnt_pkt = head[gnt_idx];

  // pointer moves past the winner; flush leaves it alone so fairness survives squashes
  always_ff @(posedge clk) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (gnt_any && !flush)
      rr_ptr <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
  end

  // broadcast register; payload is zeroed whenever nothing is broadcast
  always_ff @(posedge clk) begin
    if (!rst_n || flush || !gnt_any) begin
      cdb_valid    <= 1'b0;
      cdb_regwrite <= 1'b0;
      out_pkt      <= '0;
    end else begin
      cdb_valid    <= 1'b1;
      cdb_regwrite <= (gnt_pkt[PKT_W-1 -: PID_W] != '0);
      out_pkt      <= gnt_pkt;
    end
  end

  assign {cdb_pid, cdb_value, cdb_rob_idx} = out_pkt;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model with a scoreboard of
// expected broadcasts, a directed vector table and hand-written corner sequences.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 4;
  localparam int DEPTH   = 2;
  localparam int PID_W   = PHYS_REG_IDX + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [NUM_SRC-1:0]                src_valid = '0;
  logic [NUM_SRC-1:0]                src_ready;
  logic [NUM_SRC-1:0][PID_W-1:0]     src_pid = '0;
  logic [NUM_SRC-1:0][XLEN-1:0]      src_value = '0;
  logic [NUM_SRC-1:0][ROB_IDX_W-1:0] src_rob_idx = '0;
  logic                              cdb_valid, cdb_regwrite;
  logic [PID_W-1:0]                  cdb_pid;
  logic [XLEN-1:0]                   cdb_value;
  logic [ROB_IDX_W-1:0]              cdb_rob_idx;

  cdb_arbiter #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_pid(src_pid),
    .src_value(src_value), .src_rob_idx(src_rob_idx),
    .cdb_valid(cdb_valid), .cdb_regwrite(cdb_regwrite), .cdb_pid(cdb_pid),
    .cdb_value(cdb_value), .cdb_rob_idx(cdb_rob_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model: per-source queues plus round-robin pointer
  typedef struct packed { logic v; logic rw; cdb_pkt_t pkt; } exp_t;
  cdb_pkt_t mq [NUM_SRC][$];
  int       mptr = 0;
  exp_t     exp_q [$];
  bit       primed = 1'b0;

  // one clock: model the edge, push the expected broadcast, step, pop and compare
  task automatic cycle(input logic r, input logic f);
    exp_t e;
    cdb_pkt_t p;
    logic [NUM_SRC-1:0] mrdy;
    int j;
    e = '0;
    rst_n = r;
    flush = f;
    for (int i = 0; i < NUM_SRC; i++) mrdy[i] = (mq[i].size() < DEPTH);
    if (primed) chk("src_ready", 64'(src_ready), 64'(mrdy));
    if (!r) begin
      for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
      mptr = 0;
    end else if (f) begin
      for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        j = (mptr + k) % NUM_SRC;
        if (!e.v && mq[j].size() != 0) begin
          e.v   = 1'b1;
          e.pkt = mq[j].pop_front();
          mptr  = (j + 1) % NUM_SRC;
        end
      end
      for (int i = 0; i < NUM_SRC; i++)
        if (src_valid[i] && mrdy[i]) begin
          p.pid = src_pid[i]; p.value = src_value[i]; p.rob_idx = src_rob_idx[i];
          mq[i].push_back(p);
        end
      e.rw = e.v && (e.pkt.pid != '0);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    primed = 1'b1;
    e = exp_q.pop_front();
    chk("cdb_valid", 64'(cdb_valid), 64'(e.v));
    chk("cdb_regwrite", 64'(cdb_regwrite), 64'(e.rw));
    chk("cdb_pid", 64'(cdb_pid), 64'(e.pkt.pid));
    chk("cdb_value", 64'(cdb_value), 64'(e.pkt.value));
    chk("cdb_rob_idx", 64'(cdb_rob_idx), 64'(e.pkt.rob_idx));
  endtask

  task automatic drive(input int i, input logic [PID_W-1:0] pd, input logic [XLEN-1:0] v,
                       input logic [ROB_IDX_W-1:0] rb);
    src_valid[i] = 1'b1; src_pid[i] = pd; src_value[i] = v; src_rob_idx[i] = rb;
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  function automatic logic [31:0] vf(input logic [5:0] pd, input logic [3:0] rb);
    return {20'hC0DE0, pd, 2'b00, rb};
  endfunction

  // directed vectors: source i drives pid=pid_base+i, rob=rob_base+i
  typedef struct {
    logic [3:0] vmask;
    logic [5:0] pid_base;
    logic [3:0] rob_base;
    logic       exp_v;
    logic       exp_rw;
    logic [5:0] exp_pid;
    logic [3:0] exp_rob;
    logic [3:0] exp_rdy;
  } vec_t;
  vec_t tbl [17];

  initial begin
    // all four sources at once after reset: broadcast src0..src3 in turn
    tbl[0]  = '{4'b1111,  6'd8,  4'd8, 1'b0, 1'b0,  6'd0,  4'd0, 4'b1111};
    tbl[1]  = '{4'b0000,  6'd0,  4'd0, 1'b1, 1'b1,  6'd8,  4'd8, 4'b1111};
    tbl[2]  = '{4'b0000,  6'd0,  4'd0, 1'b1, 1'b1,  6'd9,  4'd9, 4'b1111};
    tbl[3]  = '{4'b0000,  6'd0,  4'd0, 1'b1, 1'b1, 6'd10, 4'd10, 4'b1111};
    tbl[4]  = '{4'b0000,  6'd0,  4'd0, 1'b1, 1'b1, 6'd11, 4'd11, 4'b1111};
    tbl[5]  = '{4'b0000,  6'd0,  4'd0, 1'b0, 1'b0,  6'd0,  4'd0, 4'b1111};
    // source 2 back-to-back under contention: fills, holds while not ready, drains in order
    tbl[6]  = '{4'b1111, 6'd32,  4'd0, 1'b0, 1'b0,  6'd0,  4'd0, 4'b1111};
    tbl[7]  = '{4'b0100, 6'd40,  4'd8, 1'b1, 1'b1, 6'd32,  4'd0, 4'b1011};
    tbl[8]  = '{4'b0100, 6'd44, 4'd12, 1'b1, 1'b1, 6'd33,  4'd1, 4'b1011};
    tbl[9]  = '{4'b0100, 6'd44, 4'd12, 1'b1, 1'b1, 6'd34,  4'd2, 4'b1111};
    tbl[10] = '{4'b0100, 6'd44, 4'd12, 1'b1, 1'b1, 6'd35,  4'd3, 4'b1011};
    tbl[11] = '{4'b0000,  6'd0,  4'd0, 1'b1, 1'b1, 6'd42, 4'd10, 4'b1111};
    tbl[12] = '{4'b0000,  6'd0,  4'd0, 1'b1, 1'b1, 6'd46, 4'd14, 4'b1111};
    tbl[13] = '{4'b0000,  6'd0,  4'd0, 1'b0, 1'b0,  6'd0,  4'd0, 4'b1111};
    // pid 0 still broadcasts for ROB completion, without a register write
    tbl[14] = '{4'b0001,  6'd0,  4'd7, 1'b0, 1'b0,  6'd0,  4'd0, 4'b1111};
    tbl[15] = '{4'b0000,  6'd0,  4'd0, 1'b1, 1'b0,  6'd0,  4'd7, 4'b1111};
    tbl[16] = '{4'b0000,  6'd0,  4'd0, 1'b0, 1'b0,  6'd0,  4'd0, 4'b1111};

    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("reset_ready", 64'(src_ready), 64'hF);
    chk("reset_valid", 64'(cdb_valid), 64'h0);

    foreach (tbl[n]) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        src_valid[i]   = tbl[n].vmask[i];
        src_pid[i]     = tbl[n].pid_base + 6'(i);
        src_rob_idx[i] = tbl[n].rob_base + 4'(i);
        src_value[i]   = vf(src_pid[i], src_rob_idx[i]);
      end
      cycle(1'b1, 1'b0);
      chk($sformatf("tbl%0d_valid", n), 64'(cdb_valid), 64'(tbl[n].exp_v));
      chk($sformatf("tbl%0d_rw", n), 64'(cdb_regwrite), 64'(tbl[n].exp_rw));
      chk($sformatf("tbl%0d_pid", n), 64'(cdb_pid), 64'(tbl[n].exp_pid));
      chk($sformatf("tbl%0d_rob", n), 64'(cdb_rob_idx), 64'(tbl[n].exp_rob));
      chk($sformatf("tbl%0d_value", n), 64'(cdb_value),
          64'(tbl[n].exp_v ? vf(tbl[n].exp_pid, tbl[n].exp_rob) : 32'h0));
      chk($sformatf("tbl%0d_ready", n), 64'(src_ready), 64'(tbl[n].exp_rdy));
    end

    // single result: accepted at one edge, visible only after the next
    idle(); drive(1, 6'd5, 32'hDEADBEEF, 4'd3);
    cycle(1'b1, 1'b0);
    chk("single_latency", 64'(cdb_valid), 64'h0);
    idle();
    cycle(1'b1, 1'b0);
    chk("single_valid", 64'(cdb_valid), 64'h1);
    chk("single_rw", 64'(cdb_regwrite), 64'h1);
    chk("single_pid", 64'(cdb_pid), 64'd5);
    chk("single_value", 64'(cdb_value), 64'hDEADBEEF);
    chk("single_rob", 64'(cdb_rob_idx), 64'd3);
    cycle(1'b1, 1'b0);
    chk("single_done", 64'(cdb_valid), 64'h0);

    // flush with three buffered entries; flush-cycle enqueue is ignored
    drive(0, 6'd1, 32'h11, 4'd1); drive(1, 6'd2, 32'h22, 4'd2); drive(2, 6'd3, 32'h33, 4'd3);
    cycle(1'b1, 1'b0);
    idle(); drive(3, 6'd4, 32'h44, 4'd4);
    cycle(1'b1, 1'b1);
    chk("flush_valid", 64'(cdb_valid), 64'h0);
    chk("flush_rw", 64'(cdb_regwrite), 64'h0);
    chk("flush_ready", 64'(src_ready), 64'hF);
    idle();
    for (int n = 0; n < 2; n++) begin
      cycle(1'b1, 1'b0);
      chk("flush_quiet", 64'(cdb_valid), 64'h0);
    end
    drive(3, 6'd9, 32'h1234, 4'd5);
    cycle(1'b1, 1'b0);
    idle();
    cycle(1'b1, 1'b0);
    chk("post_flush_pid", 64'(cdb_pid), 64'd9);
    chk("post_flush_value", 64'(cdb_value), 64'h1234);

    // reset while src0 is full (flush also high; reset must win and clear the pointer)
    for (int i = 0; i < NUM_SRC; i++) drive(i, 6'(i + 1), 32'(i + 100), 4'(i));
    cycle(1'b1, 1'b0);
    idle(); drive(0, 6'd11, 32'hB0B0, 4'd11);
    cycle(1'b1, 1'b0);
    drive(0, 6'd12, 32'hC0C0, 4'd12);
    cycle(1'b1, 1'b0);
    chk("src0_full", 64'(src_ready[0]), 64'h0);
    cycle(1'b0, 1'b1);
    chk("rst_valid", 64'(cdb_valid), 64'h0);
    chk("rst_ready", 64'(src_ready), 64'hF);
    chk("rst_pid", 64'(cdb_pid), 64'h0);
    idle();
    for (int n = 0; n < 3; n++) begin
      cycle(1'b1, 1'b0);
      chk("rst_no_stale", 64'(cdb_valid), 64'h0);
    end
    drive(2, 6'd22, 32'h2222, 4'd2); drive(1, 6'd21, 32'h2121, 4'd1);
    cycle(1'b1, 1'b0);
    idle();
    cycle(1'b1, 1'b0);
    chk("rst_ptr_first", 64'(cdb_pid), 64'd21);
    cycle(1'b1, 1'b0);
    chk("rst_ptr_second", 64'(cdb_pid), 64'd22);

    // random traffic against the model, with occasional flushes
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        src_valid[i]   = ($urandom_range(0, 2) != 0);
        src_pid[i]     = PID_W'($urandom);
        src_value[i]   = $urandom;
        src_rob_idx[i] = ROB_IDX_W'($urandom);
      end
      cycle(1'b1, ($urandom_range(0, 39) == 0));
    end
    idle();
    for (int n = 0; n < 10; n++) cycle(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
